// File: rtl/axis_rr_arbiter_if.sv
// ----------------------------------------------------------------------------
// axis_rr_arbiter_if
// AXI-Stream handshake bundle used by axis_rr_arbiter for its two source ports
// and its single master port.
//   tdata  : payload, DATA_W bits
//   tvalid : source has a beat on tdata
//   tlast  : beat is the last of its packet
//   tready : sink accepts the beat this cycle
// Modports:
//   master : drives tdata/tvalid/tlast, receives tready
//   slave  : receives tdata/tvalid/tlast, drives tready
// ----------------------------------------------------------------------------
interface axis_rr_arbiter_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_rr_arbiter.sv
// ----------------------------------------------------------------------------
// axis_rr_arbiter
// Packet-level round-robin arbiter sharing one AXI-Stream master port between
// two AXI-Stream sources. A granted source owns the port until its tlast beat
// is accepted, so packets never interleave. The output is a registered,
// full-throughput pipeline stage.
// Ports:
//   clock, reset       : single clock, synchronous active-high reset
//   en[1:0]            : per-source enable, gates new grants only
//   s0, s1 (slave)     : source streams
//   m (master), m_tid  : output stream and index of the source of the beat
//   busy               : a grant is held
//   grant              : current or most recent grant
//   pkt_cnt0/pkt_cnt1  : packets completed on the output per source (wrapping)
// ----------------------------------------------------------------------------
module axis_rr_arbiter #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [1:0]        en,
    axis_rr_arbiter_if.slave  s0,
    axis_rr_arbiter_if.slave  s1,
    axis_rr_arbiter_if.master m,
    output logic              m_tid,
    output logic              busy,
    output logic              grant,
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_grant;
    logic               w_grant_nxt;
    logic               r_last_grant;
    logic               r_m_tvalid;
    logic [DATA_W-1:0]  r_m_tdata;
    logic               r_m_tlast;
    logic               r_m_tid;
    logic [CNT_W-1:0]   r_cnt0;
    logic [CNT_W-1:0]   r_cnt1;

    logic [1:0]         w_req;
    logic               w_adv;
    logic               w_busy;
    logic               w_g_tvalid;
    logic               w_g_tlast;
    logic [DATA_W-1:0]  w_g_tdata;
    logic               w_accept;
    logic               w_decide;
    logic               w_pkt_done;

    assign w_req      = {s1.tvalid & en[1], s0.tvalid & en[0]};
    assign w_busy     = (r_state == BUSY);
    // The output register can take a new beat when empty or draining this cycle.
    assign w_adv      = ~r_m_tvalid | m.tready;
    assign w_g_tvalid = r_grant ? s1.tvalid : s0.tvalid;
    assign w_g_tlast  = r_grant ? s1.tlast  : s0.tlast;
    assign w_g_tdata  = r_grant ? s1.tdata  : s0.tdata;
    assign w_accept   = w_busy & w_g_tvalid & w_adv;
    assign w_decide   = ~w_busy & (|w_req);
    assign w_pkt_done = r_m_tvalid & m.tready & r_m_tlast;

    // Only the granted source sees ready; nothing is ready while deciding in IDLE.
    assign s0.tready  = w_busy & ~r_grant & w_adv;
    assign s1.tready  = w_busy &  r_grant & w_adv;

    // NOTE: every variable in this block gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        case (r_state)
            IDLE: begin
                if (|w_req) begin
                    w_state_nxt = BUSY;
                    // Tie goes to the source that did not win last time.
                    w_grant_nxt = (&w_req) ? ~r_last_grant : w_req[1];
                end
            end
            BUSY: begin
                if (w_accept && w_g_tlast) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values,
    // independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
            r_m_tvalid   <= 1'b0;
            r_m_tdata    <= '0;
            r_m_tlast    <= 1'b0;
            r_m_tid      <= 1'b0;
            r_cnt0       <= '0;
            r_cnt1       <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            if (w_decide) begin
                r_last_grant <= w_grant_nxt;
            end

            if (w_accept) begin
                r_m_tvalid <= 1'b1;
                r_m_tdata  <= w_g_tdata;
                r_m_tlast  <= w_g_tlast;
                r_m_tid    <= r_grant;
            end else if (m.tready) begin
                r_m_tvalid <= 1'b0;
            end

            if (w_pkt_done) begin
                if (r_m_tid) begin
                    r_cnt1 <= r_cnt1 + CNT_ONE;
                end else begin
                    r_cnt0 <= r_cnt0 + CNT_ONE;
                end
            end
        end
    end

    assign m.tvalid = r_m_tvalid;
    assign m.tdata  = r_m_tdata;
    assign m.tlast  = r_m_tlast;
    assign m_tid    = r_m_tid;
    assign busy     = w_busy;
    assign grant    = r_grant;
    assign pkt_cnt0 = r_cnt0;
    assign pkt_cnt1 = r_cnt1;

endmodule
